// File: rtl/bidir_visit_tracker_if.sv
// Valid/ready node-ID stream between the search stages.
interface bidir_visit_tracker_if #(
  parameter int unsigned NODE_W = 4
);
  logic              valid;
  logic              ready;
  logic [NODE_W-1:0] node;

  // Producer side of the stream.
  modport master (output valid, output node, input ready);
  // Consumer side of the stream.
  modport slave  (input valid, input node, output ready);
endinterface

// File: rtl/bidir_visit_tracker.sv
// Visited-set filter and meet detector for the bidirectional search core.
module bidir_visit_tracker #(
  parameter int unsigned NODE_W = 4
) (
  input  logic                  m_clock,
  input  logic                  p_reset,
  input  logic                  clear,
  bidir_visit_tracker_if.slave  f,
  bidir_visit_tracker_if.slave  b,
  bidir_visit_tracker_if.master fo,
  bidir_visit_tracker_if.master bo,
  output logic                  meet_valid,
  output logic [NODE_W-1:0]     meet_node,
  output logic [NODE_W:0]       f_count,
  output logic [NODE_W:0]       b_count
);

  localparam int unsigned N_NODES = 1 << NODE_W;
  localparam int unsigned CNT_W   = NODE_W + 1;

  logic [N_NODES-1:0] fvis;
  logic [N_NODES-1:0] bvis;

  logic f_new;
  logic b_new;
  logic f_meet;
  logic b_meet;

  // Accept only when the one-entry output slot is free or draining, never after a meet.
  assign f.ready = (!fo.valid || fo.ready) && !meet_valid && !clear;
  assign b.ready = (!bo.valid || bo.ready) && !meet_valid && !clear;

  // Classify this cycle's accepts as new nodes and detect meets, including same-cycle cross hits.
  always_comb begin
    f_new  = f.valid && f.ready && !fvis[f.node];
    b_new  = b.valid && b.ready && !bvis[b.node];
    f_meet = f_new && (bvis[f.node] || (b_new && (b.node == f.node)));
    b_meet = b_new && (fvis[b.node] || (f_new && (f.node == b.node)));
  end

  // Visited bitmaps, output slots, counters and sticky meet; reset/clear wins over everything.
  always_ff @(posedge m_clock) begin
    if (!p_reset || clear) begin
      fvis       <= '0;
      bvis       <= '0;
      fo.valid   <= 1'b0;
      fo.node    <= '0;
      bo.valid   <= 1'b0;
      bo.node    <= '0;
      f_count    <= '0;
      b_count    <= '0;
      meet_valid <= 1'b0;
      meet_node  <= '0;
    end else begin
      if (f_new) begin
        fvis[f.node] <= 1'b1;
        f_count      <= f_count + CNT_W'(1);
        fo.valid     <= 1'b1;
        fo.node      <= f.node;
      end else if (fo.ready) begin
        fo.valid <= 1'b0;
      end

      if (b_new) begin
        bvis[b.node] <= 1'b1;
        b_count      <= b_count + CNT_W'(1);
        bo.valid     <= 1'b1;
        bo.node      <= b.node;
      end else if (bo.ready) begin
        bo.valid <= 1'b0;
      end

      // Forward direction takes priority when both sides meet on different nodes.
      if (f_meet) begin
        meet_valid <= 1'b1;
        meet_node  <= f.node;
      end else if (b_meet) begin
        meet_valid <= 1'b1;
        meet_node  <= b.node;
      end
    end
  end

endmodule

// File: tb/tb_bidir_visit_tracker.sv
// Directed, table-driven bench for bidir_visit_tracker.
module tb_bidir_visit_tracker;

  localparam int unsigned NODE_W = 4;

  logic              m_clock;
  logic              p_reset;
  logic              clear;
  logic              meet_valid;
  logic [NODE_W-1:0] meet_node;
  logic [NODE_W:0]   f_count;
  logic [NODE_W:0]   b_count;

  bidir_visit_tracker_if #(.NODE_W(NODE_W)) f_if ();
  bidir_visit_tracker_if #(.NODE_W(NODE_W)) b_if ();
  bidir_visit_tracker_if #(.NODE_W(NODE_W)) fo_if ();
  bidir_visit_tracker_if #(.NODE_W(NODE_W)) bo_if ();

  bidir_visit_tracker #(.NODE_W(NODE_W)) dut (
    .m_clock    (m_clock),
    .p_reset    (p_reset),
    .clear      (clear),
    .f          (f_if),
    .b          (b_if),
    .fo         (fo_if),
    .bo         (bo_if),
    .meet_valid (meet_valid),
    .meet_node  (meet_node),
    .f_count    (f_count),
    .b_count    (b_count)
  );

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  typedef struct {
    int c, fv, fn, bv, bn, for_r, bor;
    int fov, fon, bov, bon, mv, mn, fc, bc, fr, br;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int c, input int fv, input int fn, input int bv, input int bn,
                     input int for_r, input int bor,
                     input int fov, input int fon, input int bov, input int bon,
                     input int mv, input int mn, input int fc, input int bc,
                     input int fr, input int br);
    vec_t v;
    v.c = c; v.fv = fv; v.fn = fn; v.bv = bv; v.bn = bn; v.for_r = for_r; v.bor = bor;
    v.fov = fov; v.fon = fon; v.bov = bov; v.bon = bon; v.mv = mv; v.mn = mn;
    v.fc = fc; v.bc = bc; v.fr = fr; v.br = br;
    vq.push_back(v);
  endtask

  task automatic drive(input int c, input int fv, input int fn, input int bv, input int bn,
                       input int for_r, input int bor);
    clear        = 1'(c);
    f_if.valid   = 1'(fv);
    f_if.node    = NODE_W'(fn);
    b_if.valid   = 1'(bv);
    b_if.node    = NODE_W'(bn);
    fo_if.ready  = 1'(for_r);
    bo_if.ready  = 1'(bor);
  endtask

  task automatic step();
    @(posedge m_clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input int fov, input int fon, input int bov,
                         input int bon, input int mv, input int mn, input int fc,
                         input int bc, input int fr, input int br);
    chk({tag, " fo_valid"},   int'(fo_if.valid), fov);
    chk({tag, " fo_node"},    int'(fo_if.node),  fon);
    chk({tag, " bo_valid"},   int'(bo_if.valid), bov);
    chk({tag, " bo_node"},    int'(bo_if.node),  bon);
    chk({tag, " meet_valid"}, int'(meet_valid),  mv);
    chk({tag, " meet_node"},  int'(meet_node),   mn);
    chk({tag, " f_count"},    int'(f_count),     fc);
    chk({tag, " b_count"},    int'(b_count),     bc);
    chk({tag, " f_ready"},    int'(f_if.ready),  fr);
    chk({tag, " b_ready"},    int'(b_if.ready),  br);
  endtask

  initial begin
    int cyc;

    //   c fv fn bv bn fo bo | fov fon bov bon mv mn fc bc fr br
    // duplicate filtering: 3,5,3,5,7
    add(0, 1, 3, 0, 0, 1, 1,   1, 3, 0, 0, 0, 0, 1, 0, 1, 1);
    add(0, 1, 5, 0, 0, 1, 1,   1, 5, 0, 0, 0, 0, 2, 0, 1, 1);
    add(0, 1, 3, 0, 0, 1, 1,   0, 5, 0, 0, 0, 0, 2, 0, 1, 1);
    add(0, 1, 5, 0, 0, 1, 1,   0, 5, 0, 0, 0, 0, 2, 0, 1, 1);
    add(0, 1, 7, 0, 0, 1, 1,   1, 7, 0, 0, 0, 0, 3, 0, 1, 1);
    // clear while fo_valid=1 and f_count=3, with a handshake attempt
    add(1, 1, 3, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 1, 3, 0, 0, 1, 1,   1, 3, 0, 0, 0, 0, 1, 0, 1, 1);
    // meet across cycles: fwd 0 then 2, bwd 15 then 2
    add(0, 1, 0, 1,15, 1, 1,   1, 0, 1,15, 0, 0, 2, 1, 1, 1);
    add(0, 1, 2, 0, 0, 1, 1,   1, 2, 0,15, 0, 0, 3, 1, 1, 1);
    add(0, 0, 0, 1, 2, 1, 1,   0, 2, 1, 2, 1, 2, 3, 2, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,   0, 2, 0, 2, 1, 2, 3, 2, 0, 0);
    add(0, 1, 9, 1, 9, 1, 1,   0, 2, 0, 2, 1, 2, 3, 2, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // simultaneous meet on node 9
    add(0, 1, 9, 1, 9, 1, 1,   1, 9, 1, 9, 1, 9, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,   1, 9, 0, 9, 1, 9, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // backpressure: 4 held, 6 stalled, then pass-through
    add(0, 1, 4, 0, 0, 0, 1,   1, 4, 0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 1, 6, 0, 0, 0, 1,   1, 4, 0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 1, 6, 0, 0, 1, 1,   1, 6, 0, 0, 0, 0, 2, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 1,   0, 6, 0, 0, 0, 0, 2, 0, 1, 1);
    // duplicate in the cycle right after its accept
    add(0, 1, 8, 0, 0, 1, 1,   1, 8, 0, 0, 0, 0, 3, 0, 1, 1);
    add(0, 1, 8, 0, 0, 1, 1,   0, 8, 0, 0, 0, 0, 3, 0, 1, 1);
    // two different meets in one cycle: forward (1) wins over backward (4)
    add(0, 0, 0, 1, 1, 1, 1,   0, 8, 1, 1, 0, 0, 3, 1, 1, 1);
    add(0, 1, 1, 1, 4, 1, 1,   1, 1, 1, 4, 1, 1, 4, 2, 0, 0);

    // reset held for two cycles
    drive(0, 0, 0, 0, 0, 1, 1);
    p_reset = 1'b0;
    step();
    step();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    p_reset = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].c, vq[i].fv, vq[i].fn, vq[i].bv, vq[i].bn, vq[i].for_r, vq[i].bor);
      step();
      chk_all($sformatf("v%0d", i), vq[i].fov, vq[i].fon, vq[i].bov, vq[i].bon,
              vq[i].mv, vq[i].mn, vq[i].fc, vq[i].bc, vq[i].fr, vq[i].br);
    end

    // pending output drains after the meet despite ready being low
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    chk_all("drain_hold", 1, 1, 0, 4, 1, 1, 4, 2, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1);
    step();
    chk_all("drain_done", 0, 1, 0, 4, 1, 1, 4, 2, 0, 0);

    // reset during a handshake discards everything
    drive(0, 1, 12, 1, 12, 1, 1);
    p_reset = 1'b0;
    step();
    chk_all("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    p_reset = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 1);
    step();

    // previously visited node 1 is new again after reset; bounded wait for output
    drive(0, 1, 1, 0, 0, 1, 1);
    step();
    drive(0, 0, 0, 0, 0, 1, 1);
    cyc = 0;
    while (!fo_if.valid && cyc < 5) begin
      step();
      cyc++;
    end
    chk("post_rst fo_valid", int'(fo_if.valid), 1);
    chk("post_rst fo_node", int'(fo_if.node), 1);
    chk("post_rst f_count", int'(f_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bidir_visit_tracker.md
# bidir_visit_tracker

Visited-set and meet-detection stage of the bidirectional search core. It sits directly downstream of the forward and backward expansion units and upstream of the two frontier queues. It accepts candidate node IDs from each search direction and drops nodes that direction has already visited. New nodes are forwarded to that direction's frontier queue. When a node has been visited by both directions, the block latches it as the meet node.

## Interface
Parameters:
- NODE_W, 4, node ID width; the graph holds 2^NODE_W nodes.

Ports:
- m_clock  in  1  clock. One clock domain; all state updates on the rising edge.
- p_reset  in  1  reset, synchronous, active-low.
- clear  in  1  synchronous restart of a search. Same effect as reset.
- f_valid / f_ready  in / out  1 / 1  forward candidate handshake.
- f_node  in  NODE_W  forward candidate ID.
- b_valid / b_ready  in / out  1 / 1  backward candidate handshake.
- b_node  in  NODE_W  backward candidate ID.
- fo_valid / fo_ready  out / in  1 / 1  new-forward-node handshake to the forward frontier queue.
- fo_node  out  NODE_W  new forward node.
- bo_valid / bo_ready  out / in  1 / 1  new-backward-node handshake to the backward frontier queue.
- bo_node  out  NODE_W  new backward node.
- meet_valid  out  1  sticky; high once a meet is found.
- meet_node  out  NODE_W  meeting node. Valid only while meet_valid is high.
- f_count, b_count  out  NODE_W+1  number of distinct nodes visited per direction.

## Operation
- State:
  - bitmaps fvis[2^NODE_W] and bvis[2^NODE_W];
  - one-entry output registers (fo_*, bo_*);
  - meet_valid and meet_node;
  - the two counters.
- Reset or clear: all state cleared. Every output is 0, except f_ready and b_ready, which follow the rule below.
- Ready rule: f_ready = !fo_valid || fo_ready, gated low when meet_valid or clear is high. b_ready uses the same rule with bo_valid / bo_ready.
- A forward accept (f_valid && f_ready) with fvis[f_node]=0:
  - set fvis[f_node];
  - increment f_count;
  - load fo_node <= f_node and set fo_valid <= 1.
- A forward accept with fvis[f_node]=1: the candidate is dropped. No output and no count change; if fo_fire occurs in the same cycle, fo_valid goes to 0.
- The backward direction behaves symmetrically.
- Otherwise fo_valid goes to 0 on fo_fire and holds while fo_ready is low; fo_node holds while fo_valid is high.
- Meet: a new forward node N is a meet if bvis[N]=1 before the edge, or if the backward side accepts N as new in the same cycle. The backward case is symmetric. On a meet, set meet_valid and meet_node <= N. The meet node is still emitted on fo/bo.
- Simultaneous meets on different nodes in one cycle: the forward node wins.
- After meet_valid is set:
  - no further accepts, because ready is low;
  - any pending fo/bo output still drains normally.
- Counters never overflow: at most 2^NODE_W nodes, which fits NODE_W+1 bits.
- Same node on both inputs in one cycle, new to both sides: both bitmaps are set, both outputs are loaded, and meet_node = that node.

## Timing
- Accept at edge N: fo_valid/bo_valid, the count increment, and meet_valid are all visible after edge N. This is 1-cycle latency.
- The bitmap bit is visible to a duplicate check from the next cycle. A duplicate offered in the cycle right after an accept is dropped.
- Full throughput is 1 accept per direction per cycle while fo_ready/bo_ready are held high.
- With fo_ready low and fo_valid high, f_ready is low and the forward state is frozen.
- clear or p_reset low in any cycle, including during a handshake, wins over everything. In-flight outputs are discarded, and the outputs read 0 after that edge.

## Test plan
- Reset: hold p_reset=0 for 2 cycles, then release. All outputs are 0, f_ready=b_ready=1, counts are 0.
- Duplicate filtering: offer forward 3, 5, 3, 5, 7 with fo_ready=1. fo emits exactly 3, 5, 7, and f_count ends at 3.
- Meet across cycles:
  - offer forward 0 then 2, and backward 15 then 2, on separate cycles;
  - meet_valid rises 1 cycle after the second node-2 accept, with meet_node=2;
  - f_ready and b_ready then go low.
- Simultaneous meet: after a clear, forward 9 and backward 9 are accepted in the same cycle. The next cycle shows meet_valid=1, meet_node=9, and fo_node=bo_node=9, both valid.
- Backpressure: fo_ready=0 while forward 4, then 6, are offered. Node 4 is held on fo, f_ready=0, and node 6 is not accepted. After fo_ready=1, node 4 is consumed, then node 6 is accepted and emitted.
- Clear mid-operation: assert clear for one cycle while fo_valid=1 and f_count=3. The next cycle shows all outputs 0, and re-offering previously visited nodes yields new outputs.
